palette_update_controller: RTL

Sequences colour palette updates so the display never tears. SPI-side writes land in a 16-entry shadow table with a per-entry dirty mask. On commit, the controller waits for vertical blanking and replays only the dirty entries into the palette's single write port, one entry per cycle. It sits between the SPI register interface and the palette's assign_color_* port in the graphics pipeline.

---
 rtl/palette_update_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/palette_update_controller.sv
// Palette update sequencer: SPI writes land in a 16-entry shadow table and a commit replays
// only the dirty entries into the palette write port during vertical blanking.
module palette_update_controller #(
    parameter bit         SYNC_TO_BLANK = 1'b1,
    parameter logic [9:0] VOID_COLOR    = 10'b0000_100_100,
    parameter logic [9:0] WHITE_COLOR   = 10'b1111_100_100
) (
    input  logic       clock_in,
    input  logic       reset_n_in,
    input  logic       write_valid_in,
    output logic       write_ready_out,
    input  logic [3:0] write_index_in,
    input  logic [9:0] write_value_in,
    input  logic       commit_in,
    input  logic       frame_blank_in,
    output logic       assign_color_enable_out,
    output logic [3:0] assign_color_index_out,
    output logic [9:0] assign_color_value_out,
    output logic       busy_out,
    output logic       done_out
);

    typedef enum logic [1:0] {StIdle, StArmed, StApply} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        pending_q, pending_d;
    logic [15:0] dirty_q, dirty_d;
    logic [9:0]  shadow_q [16];

    logic        enable_d, done_d;
    logic [3:0]  index_d;
    logic [9:0]  value_d;
    logic [15:0] dirty_set, dirty_clr;
    logic        write_fire;

    // Shadow writes are blocked during a pass, so they never race the dirty clear below.
    assign write_ready_out = (state_q != StApply);
    assign write_fire      = write_valid_in && write_ready_out;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        enable_d  = 1'b0;
        done_d    = 1'b0;
        index_d   = assign_color_index_out;
        value_d   = assign_color_value_out;
        dirty_set = '0;
        dirty_clr = '0;

        if (write_fire) begin
            dirty_set[write_index_in] = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (commit_in) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (!SYNC_TO_BLANK || frame_blank_in) begin
                    state_d = StApply;
                    ptr_d   = 4'd0;
                end
            end
            StApply: begin
                if (commit_in) begin
                    pending_d = 1'b1;
                end
                if (dirty_q[ptr_q]) begin
                    enable_d         = 1'b1;
                    index_d          = ptr_q;
                    value_d          = shadow_q[ptr_q];
                    dirty_clr[ptr_q] = 1'b1;
                end
                ptr_d = ptr_q + 4'd1;
                if (ptr_q == 4'd15) begin
                    done_d = 1'b1;
                    // A commit landing on the final edge still re-arms.
                    state_d   = (pending_q || commit_in) ? StArmed : StIdle;
                    pending_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        dirty_d = (dirty_q & ~dirty_clr) | dirty_set;
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q                 <= StIdle;
            ptr_q                   <= 4'd0;
            pending_q               <= 1'b0;
            dirty_q                 <= '0;
            assign_color_enable_out <= 1'b0;
            assign_color_index_out  <= 4'd0;
            assign_color_value_out  <= 10'd0;
            busy_out                <= 1'b0;
            done_out                <= 1'b0;
        end else begin
            state_q                 <= state_d;
            ptr_q                   <= ptr_d;
            pending_q               <= pending_d;
            dirty_q                 <= dirty_d;
            assign_color_enable_out <= enable_d;
            assign_color_index_out  <= index_d;
            assign_color_value_out  <= value_d;
            busy_out                <= (state_d != StIdle);
            done_out                <= done_d;
        end
    end

    // Defaults match the palette's own reset so both tables agree after reset.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            shadow_q[0] <= VOID_COLOR;
            for (int i = 1; i < 16; i++) begin
                shadow_q[i] <= WHITE_COLOR;
            end
        end else if (write_fire) begin
            shadow_q[write_index_in] <= write_value_in;
        end
    end

endmodule
